// File: rtl/output_deskew_writer.sv
// De-skews per-column systolic-array results into aligned rows and writes each row
// to the output buffer at offset + row index.
module output_deskew_writer #(
  parameter  int WIDTH  = 8,
  parameter  int COL    = 4,
  parameter  int O_SIZE = 256,
  localparam int AW     = $clog2(O_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        num_rows_i,
  input  logic [AW-1:0]        o_offset_i,
  input  logic [COL-1:0]       sa_valid_i,
  input  logic [COL*WIDTH-1:0] sa_data_i,
  output logic                 ob_mem_cenb_o,
  output logic                 ob_mem_wenb_o,
  output logic [AW-1:0]        ob_mem_addr_o,
  output logic [COL*WIDTH-1:0] ob_mem_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [AW-1:0]        r_num_rows;
  logic [AW-1:0]        r_offset;
  logic [AW-1:0]        r_row_cnt;
  logic                 r_last;
  logic                 r_err;
  logic                 r_cenb;
  logic                 r_wenb;
  logic [AW-1:0]        r_addr;
  logic [COL*WIDTH-1:0] r_data;

  logic                 w_start;
  logic                 w_accept;
  logic                 w_partial;
  logic                 w_shift;
  logic [COL-1:0]       w_in_v;
  logic [COL-1:0]       w_dv;
  logic [COL*WIDTH-1:0] w_dd;

  // Valids are only admitted while a job runs; anything outside RUN is discarded.
  assign w_in_v = (r_state == S_RUN) ? sa_valid_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RUN leaves for DONE the cycle the last write is on the port, so done_o
  // lands one cycle after that write; rows arriving meanwhile are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_partial   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        if (r_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_accept  = &w_dv;
          w_partial = (|w_dv) && !(&w_dv);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Delay lines shift only while staying in RUN; otherwise they flush to zero.
  assign w_shift = (r_state == S_RUN) && (w_state_nxt == S_RUN);

  for (genvar c = 0; c < COL; c++) begin : g_col
    localparam int unsigned D = COL - 1 - c;
    if (D == 0) begin : g_pass
      assign w_dv[c]                = w_in_v[c];
      assign w_dd[c*WIDTH +: WIDTH] = sa_data_i[c*WIDTH +: WIDTH];
    end else begin : g_dly
      logic [D-1:0]       r_v;
      logic [D*WIDTH-1:0] r_d;

      always_ff @(posedge clk_i) begin
        if (rst_i || !w_shift) begin
          r_v <= '0;
          r_d <= '0;
        end else begin
          r_v[0]         <= w_in_v[c];
          r_d[0 +: WIDTH] <= sa_data_i[c*WIDTH +: WIDTH];
          for (int unsigned i = 1; i < D; i++) begin
            r_v[i]             <= r_v[i-1];
            r_d[i*WIDTH +: WIDTH] <= r_d[(i-1)*WIDTH +: WIDTH];
          end
        end
      end

      assign w_dv[c]                = r_v[D-1];
      assign w_dd[c*WIDTH +: WIDTH] = r_d[(D-1)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_num_rows <= '0;
      r_offset   <= '0;
      r_row_cnt  <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_cenb     <= 1'b1;
      r_wenb     <= 1'b1;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_cenb <= 1'b1;
      r_wenb <= 1'b1;
      r_last <= 1'b0;
      if (w_start) begin
        r_num_rows <= num_rows_i;
        r_offset   <= o_offset_i;
        r_row_cnt  <= '0;
        r_err      <= 1'b0;
      end
      if (w_accept) begin
        r_cenb    <= 1'b0;
        r_wenb    <= 1'b0;
        r_addr    <= r_offset + r_row_cnt;
        r_data    <= w_dd;
        r_row_cnt <= r_row_cnt + 1'b1;
        r_last    <= (r_row_cnt == r_num_rows);
      end
      if (w_partial) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ob_mem_cenb_o = r_cenb;
  assign ob_mem_wenb_o = r_wenb;
  assign ob_mem_addr_o = r_addr;
  assign ob_mem_data_o = r_data;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign err_o         = r_err;

endmodule

// File: tb/tb_output_deskew_writer.sv
// Scoreboard bench for output_deskew_writer: stimulus pushes expected writes and
// done pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_output_deskew_writer;

  localparam int WIDTH  = 8;
  localparam int COL    = 4;
  localparam int O_SIZE = 256;
  localparam int AW     = 8;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic [AW-1:0]        num_rows_i;
  logic [AW-1:0]        o_offset_i;
  logic [COL-1:0]       sa_valid_i;
  logic [COL*WIDTH-1:0] sa_data_i;
  logic                 ob_mem_cenb_o;
  logic                 ob_mem_wenb_o;
  logic [AW-1:0]        ob_mem_addr_o;
  logic [COL*WIDTH-1:0] ob_mem_data_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  output_deskew_writer #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .num_rows_i    (num_rows_i),
    .o_offset_i    (o_offset_i),
    .sa_valid_i    (sa_valid_i),
    .sa_data_i     (sa_data_i),
    .ob_mem_cenb_o (ob_mem_cenb_o),
    .ob_mem_wenb_o (ob_mem_wenb_o),
    .ob_mem_addr_o (ob_mem_addr_o),
    .ob_mem_data_o (ob_mem_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   cyc;
    logic [AW-1:0]        addr;
    logic [COL*WIDTH-1:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  int  exp_n;
  int  exp_off;
  int  exp_cnt;
  bit  exp_active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] elem(input int r, input int c);
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rr;
    b  = WIDTH'((c + 1) * 17);
    rr = WIDTH'(r);
    return b ^ rr;
  endfunction

  function automatic logic [COL*WIDTH-1:0] row_data(input int r);
    logic [COL*WIDTH-1:0] d;
    d = '0;
    for (int c = 0; c < COL; c++) d[c*WIDTH +: WIDTH] = elem(r, c);
    return d;
  endfunction

  // Monitor: every write and every done pulse must match the head of its queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (ob_mem_cenb_o === 1'b0) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", {56'd0, ob_mem_addr_o}, 64'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("wr_addr", {56'd0, ob_mem_addr_o}, {56'd0, e.addr});
          check("wr_data", {32'd0, ob_mem_data_o}, {32'd0, e.data});
          check("wr_wenb", {63'd0, ob_mem_wenb_o}, 64'd0);
        end
      end
      if (done_o === 1'b1) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
        end else begin
          check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cenb"}, {63'd0, ob_mem_cenb_o}, 64'd1);
    check({tag, "_wenb"}, {63'd0, ob_mem_wenb_o}, 64'd1);
    check({tag, "_addr"}, {56'd0, ob_mem_addr_o}, 64'd0);
    check({tag, "_data"}, {32'd0, ob_mem_data_o}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_done"}, {63'd0, done_o}, 64'd0);
    check({tag, "_err"},  {63'd0, err_o}, 64'd0);
  endtask

  task automatic do_start(input int nm1, input int off);
    start_i    = 1'b1;
    num_rows_i = AW'(nm1);
    o_offset_i = AW'(off);
    tick();
    start_i    = 1'b0;
    exp_n      = nm1;
    exp_off    = off;
    exp_cnt    = 0;
    exp_active = 1'b1;
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
  endtask

  // Row r, column c is driven in cycle t0+r+c; drop_row loses its column-2 valid;
  // rst_k >= 0 pulses reset in cycle t0+rst_k.
  task automatic send_rows(input int nrows, input int drop_row, input int rst_k);
    int  t0;
    int  wc;
    int  r;
    bit  v;
    wr_t e;
    t0 = cyc;
    for (int rr = 0; rr < nrows; rr++) begin
      wc = t0 + rr + COL;
      if (rr == drop_row) continue;
      if (rst_k >= 0 && wc > t0 + rst_k) continue;
      if (!exp_active) continue;
      e.cyc  = wc;
      e.addr = AW'(exp_off + exp_cnt);
      e.data = row_data(rr);
      exp_wr.push_back(e);
      if (exp_cnt == exp_n) begin
        exp_done.push_back(wc + 1);
        exp_active = 1'b0;
      end
      exp_cnt++;
    end
    for (int k = 0; k < nrows + COL - 1; k++) begin
      for (int c = 0; c < COL; c++) begin
        r = k - c;
        v = (r >= 0) && (r < nrows) && !(r == drop_row && c == 2);
        sa_valid_i[c] = v;
        sa_data_i[c*WIDTH +: WIDTH] = v ? elem(r, c) : 8'hEE;
      end
      rst_i = (k == rst_k);
      if (rst_k >= 0 && k == rst_k + 1) check_reset_outputs("after_rst");
      if (drop_row >= 0 && k == drop_row + COL - 1) check("err_before_partial", {63'd0, err_o}, 64'd0);
      if (drop_row >= 0 && k == drop_row + COL)     check("err_after_partial", {63'd0, err_o}, 64'd1);
      tick();
    end
    sa_valid_i = '0;
    rst_i      = 1'b0;
    if (rst_k >= 0) exp_active = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && (exp_wr.size() != 0 || exp_done.size() != 0); i++) tick();
    repeat (3) tick();
    check({tag, "_pending_writes"}, 64'(exp_wr.size()), 64'd0);
    check({tag, "_pending_done"}, 64'(exp_done.size()), 64'd0);
    check({tag, "_idle_busy"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    num_rows_i = '0;
    o_offset_i = '0;
    sa_valid_i = '0;
    sa_data_i  = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick();

    // Single row at 0x10: data 0x44332211, write at t+4, done at t+5.
    do_start(0, 'h10);
    send_rows(1, -1, -1);
    drain("single");

    // Address wrap 0xFE..0x01 with back-to-back rows.
    do_start(3, 'hFE);
    send_rows(4, -1, -1);
    drain("wrap");

    // Misaligned row 1 dropped; a later full row completes the job.
    do_start(2, 'h30);
    send_rows(3, 1, -1);
    repeat (4) tick();
    check("err_sticky", {63'd0, err_o}, 64'd1);
    check("busy_waiting_row", {63'd0, busy_o}, 64'd1);
    send_rows(1, -1, -1);
    drain("misalign");
    check("err_held_idle", {63'd0, err_o}, 64'd1);

    // Restart mid-job is ignored; start clears err.
    do_start(1, 'h20);
    check("err_cleared_by_start", {63'd0, err_o}, 64'd0);
    send_rows(1, -1, -1);
    start_i    = 1'b1;
    num_rows_i = 8'd7;
    o_offset_i = 8'h90;
    tick();
    start_i    = 1'b0;
    send_rows(1, -1, -1);
    drain("restart_ignored");

    // Valid toggling while idle must produce nothing.
    for (int i = 0; i < 8; i++) begin
      sa_valid_i = (i % 2 == 0) ? 4'hF : 4'h5;
      sa_data_i  = $urandom;
      tick();
    end
    sa_valid_i = '0;
    repeat (COL + 2) tick();
    check("idle_toggle_err", {63'd0, err_o}, 64'd0);
    check("idle_toggle_busy", {63'd0, busy_o}, 64'd0);

    // Reset after two of four rows are written.
    do_start(3, 'h40);
    send_rows(4, -1, 5);
    drain("reset_abort");
    do_start(0, 'h00);
    send_rows(1, -1, -1);
    drain("after_reset_job");

    // Full buffer: 256 rows from 0x80 wrapping to 0x7F.
    do_start(255, 'h80);
    send_rows(256, -1, -1);
    drain("full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
